// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide: XLEN+1 cycles accept-to-done (1 for divide corner cases).
// Backpressure: stall_o holds the pipeline while an op is pending; flush_i aborts and releases it at once.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  b_q, hi_q, lo_q, result_q;

  // Operand conversion at accept
  logic            is_div, a_signed, b_signed, sa, sb, neg_d;
  logic            div_zero, div_ovf, corner, accept, last;
  logic [XLEN-1:0] mag_a, mag_b, corner_res;

  always_comb begin
    is_div     = op_i[2];
    a_signed   = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_signed   = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    sa         = a_signed & rs1_i[XLEN-1];
    sb         = b_signed & rs2_i[XLEN-1];
    mag_a      = sa ? -rs1_i : rs1_i;
    mag_b      = sb ? -rs2_i : rs2_i;
    // REM takes the sign of the dividend; everything else the product of signs
    neg_d      = (is_div && op_i[1]) ? sa : (sa ^ sb);
    div_zero   = (rs2_i == '0);
    div_ovf    = ~op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    corner     = is_div && (div_zero || div_ovf);
    corner_res = '0;
    if (div_zero) corner_res = op_i[1] ? rs1_i : '1;
    else          corner_res = op_i[1] ? '0 : rs1_i;
  end

  // One iteration: hi/lo hold {acc,multiplier} for multiply and {rem,quot} for divide
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   hi_nx, lo_nx, quot_s, rem_s, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = ~div_diff[XLEN];
    if (op_q[2]) begin
      hi_nx = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -lo_nx : lo_nx;
    rem_s  = neg_q ? -hi_nx : hi_nx;
    case (op_q)
      3'd0:       final_res = prod_s[XLEN-1:0];
      3'd4, 3'd5: final_res = quot_s;
      3'd6, 3'd7: final_res = rem_s;
      default:    final_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    accept  = (state_q == IDLE) && valid_i && !flush_i;
    last    = (state_q == CALC) && (cnt_q == CNT_W'(XLEN-1));
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = corner ? DONE : CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= op_i;
      neg_q <= neg_d;
      b_q   <= mag_b;
      hi_q  <= '0;
      lo_q  <= mag_a;
      cnt_q <= '0;
      if (corner) result_q <= corner_res;
    end else if (state_q == CALC) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (last) result_q <= final_res;
    end
  end

  assign done_o   = (state_q == DONE);
  assign stall_o  = valid_i & ~done_o & ~flush_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, corner sequences and random ops against an arithmetic model.
module tb_muldiv_seq;

  logic        clk, rst_n, flush_i, valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics with plain 64-bit and signed integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      la, lb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    ia = a; ib = b;
    la = ia; lb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    r = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = la * lb; r = p[63:32]; end
      3'd2: begin p = la * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = ia / ib;
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
            else r = ia % ib;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Issue one op with valid held until done; lat = cycles from valid to the done cycle (-1 on timeout)
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stalls);
    op_i = op; rs1_i = a; rs2_i = b; valid_i = 1'b1;
    lat = -1; stalls = 0; res = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_o) begin
        res = result_o;
        lat = c;
        break;
      end
      if (stall_o) stalls++;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  vec_t        vt[13];
  logic [31:0] res, prev, r1, r2, ra, rb;
  int          lat, stalls, dones, t1, t2;
  logic [2:0]  rop;

  initial begin
    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vt[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vt[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vt[3]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vt[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vt[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vt[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vt[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vt[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};

    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {31'b0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, res, lat, stalls);
      check($sformatf("tbl%0d_result", i), res, vt[i].exp);
      check($sformatf("tbl%0d_latency", i), lat, vt[i].lat);
      check($sformatf("tbl%0d_stall_cycles", i), stalls, vt[i].lat);
      @(negedge clk);
      check($sformatf("tbl%0d_done_single", i), {31'b0, done_o}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a DIVU
    op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; valid_i = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0; valid_i = 1'b0;
    #1;
    check("midreset_done", {31'b0, done_o}, 32'd0);
    check("midreset_result", result_o, 32'd0);
    check("midreset_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, stalls);
    check("postreset_mulhu", res, 32'hFFFF_FFFE);
    check("postreset_latency", lat, 33);

    // Flush part-way through a divide
    prev = result_o;
    op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; valid_i = 1'b1;
    @(posedge clk); #1;
    repeat (12) @(posedge clk);
    #1;
    check("preflush_stall", {31'b0, stall_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush_stall_drop", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("flush_no_done", dones, 32'd0);
    check("flush_result_kept", result_o, prev);
    @(posedge clk); #1;
    do_op(3'd7, 32'd1000, 32'd3, res, lat, stalls);
    check("postflush_remu", res, 32'd1);
    check("postflush_latency", lat, 33);

    // Back-to-back with valid held high across both ops
    op_i = 3'd0; rs1_i = 32'd123456; rs2_i = 32'd789; valid_i = 1'b1;
    dones = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_o) begin
        dones++;
        if (dones == 1) begin
          t1 = c; r1 = result_o;
          @(posedge clk); #1;
          op_i = 3'd4; rs1_i = 32'hFFFF_FC18; rs2_i = 32'd7;
        end else begin
          t2 = c; r2 = result_o;
          break;
        end
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("b2b_done_count", dones, 32'd2);
    check("b2b_spacing", t2 - t1, 32'd34);
    check("b2b_mul", r1, model(3'd0, 32'd123456, 32'd789));
    check("b2b_div", r2, 32'hFFFF_FF72);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("b2b_no_extra_done", dones, 32'd0);
    @(posedge clk); #1;

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      do_op(rop, ra, rb, res, lat, stalls);
      check($sformatf("rnd%0d_op%0d_%08h_%08h", i, rop, ra, rb), res, model(rop, ra, rb));
      check($sformatf("rnd%0d_latency", i), lat, model_lat(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M instructions the decoder flags (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the EX-stage ALU. Accepts one M-op at a time, runs a shift-add multiply or restoring divide over XLEN cycles, and stalls the pipeline until the result is ready.
- Owns its operand, accumulator and counter registers, plus the RISC-V divide corner-case rules.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush_i  input  1  pipeline flush; aborts any op in flight.
- valid_i  input  1  EX holds an M-op; held high with stable operands while stall_o=1.
- op_i  input  3  funct3 of the M-op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  input  XLEN  operand A.
- rs2_i  input  XLEN  operand B.
- stall_o  output  1  freeze IF/ID/EX; combinational = valid_i & ~done_o & ~flush_i.
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  XLEN  result, held until the next accept.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, cnt=0, done_o=0, result_o=0, all internal registers 0.
- State IDLE:
  - valid_i=1 and flush_i=0 at an edge → accept: latch op_i and operand signs.
  - Corner case → DONE next edge (1-cycle latency):
    - Divide by zero (rs2_i=0): DIV/DIVU result = all ones; REM/REMU result = rs1_i.
    - Signed overflow, DIV/REM only (rs1_i=0x8000_0000, rs2_i=0xFFFF_FFFF): DIV result = 0x8000_0000; REM result = 0.
  - Otherwise → CALC with cnt=0.
  - Operand conversion on accept:
    - Signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both) are converted to magnitudes.
    - Result sign: MUL/MULH/MULHSU = sA^sB. DIV = sA^sB. REM = sA (sign of dividend).
- State CALC, one iteration per cycle:
  - Multiply: if multiplier LSB=1, acc_hi += multiplicand; then the 2·XLEN product shifts right 1.
  - Divide (restoring): shift {rem,quot} left 1; if rem ≥ divisor, rem -= divisor and set quot LSB.
  - cnt increments. At cnt=XLEN-1 the iteration completes → DONE; the final signed correction (two's-complement negate if the sign flag is set) is applied when loading result_o.
- Result selection:
  - MUL = product[XLEN-1:0].
  - MULH/MULHSU/MULHU = product[2·XLEN-1:XLEN].
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- State DONE: done_o=1 for exactly this cycle; stall_o=0 so the pipeline advances; → IDLE next edge. valid_i in DONE is the same op and is not re-accepted.
- Latency: accept edge T0; CALC occupies T1..T32 (XLEN=32); done_o high in the cycle after edge T32. Corner case: done_o high in the cycle after edge T0.
- flush_i=1:
  - stall_o=0 immediately.
  - Any state → IDLE next edge; cnt=0; done_o stays 0; result_o keeps its previous value.
  - flush_i together with valid_i in IDLE: not accepted.
- valid_i dropping mid-CALC (illegal): the sequencer continues and still pulses done_o.
- Back-to-back M-ops: the next op is accepted in the IDLE cycle after DONE (one bubble cycle minimum).
- No combinational path from rs1_i/rs2_i to any output.

Test Plan:
- Reset mid-CALC (rst_n low at cycle 10 of a DIVU) → all outputs 0, state IDLE immediately; a new MULHU accepted after release completes normally.
- MUL 7 × -3 (rs1=7, rs2=0xFFFF_FFFD) → done_o after 33 cycles, result 0xFFFF_FFEB; stall_o high exactly 33 cycles. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. MULHSU -1 × 0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV -7 / 2 → 0xFFFF_FFFD. REM -7 / 2 → 0xFFFF_FFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Corner cases: DIVU 5 / 0 → 0xFFFF_FFFF, done_o 1 cycle after accept; REM 5 / 0 → 5; DIV 0x8000_0000 / -1 → 0x8000_0000; REM same operands → 0.
- flush_i at CALC cycle 12 → stall_o drops the same cycle, no done_o pulse, IDLE next cycle, result_o unchanged; a following op runs normally.
- Back-to-back MUL then DIV with valid_i continuously high → two done_o pulses separated by 34 cycles with correct results, and no double-accept of the first op.
